clock_disp_scanner: RTL and testbench
=====================================

Name: clock_disp_scanner

Overview:
- Parametrised, time-multiplexed seven-segment driver for the digital clock.
- Takes the binary hour/minute/second time and the set-mode field selector. Drives one shared segment bus plus per-digit enables.
- Adds to the single-mode decoder: 12/24-hour selection, 4 or 6 digits, a field-blink generator for set mode, and frame-coherent input capture.
- Sits between the timekeeping/set FSM and the board display pins.

Parameters:
- NUM_DIGITS, 6, digit count. Legal values are 4 (HH:MM) and 6 (HH:MM:SS); any other value is a synthesis error.
- SCAN_DIV, 1000, clk cycles each digit is held active; legal when ≥2.
- BLINK_DIV, 500000, clk cycles per blink half-period; legal when ≥2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- is_on  input  1  display enable
- mode_24h  input  1  1 = 24-hour display, 0 = 12-hour display
- hour  input  5  current hour in 24h binary, 0..23
- minute  input  6  0..59
- second  input  6  0..59; ignored when NUM_DIGITS=4
- current_set_state  input  2  field being set: 0 none, 1 hour, 2 minute, 3 second
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- digit_en  output  NUM_DIGITS  digit anodes, active-low; bit 0 is the rightmost digit
- pm_led  output  1  PM indicator, active-high

Behaviour:
- Reset (rst_n=0 at a clk edge): scan counter=0, digit index=0, blink counter=0, blink phase=visible, snapshot registers=0. Outputs: seg=7'h7F, dp=1, digit_en=all 1, pm_led=0.
- Scan counter: counts 0..SCAN_DIV-1. When it wraps, the digit index advances 0→1→…→NUM_DIGITS-1→0.
- Frame snapshot: when the index wraps to 0, or on the first cycle after reset, hour/minute/second/mode_24h are captured. One full frame always displays a single coherent time.
  - current_set_state is not snapshotted.
- Output latency: seg, dp and digit_en are registered and update 1 clk after the index changes. Exactly one digit_en bit is low per cycle when enabled.
- Digit map (6 digits), index 5..0: H tens, H units, M tens, M units, S tens, S units. For 4 digits, index 3..0: H tens, H units, M tens, M units.
- dp is low on H units and on M units. For NUM_DIGITS=4, dp is low on H units only.
- 12h conversion:
  - Display hour 0 → 12.
  - Hours 13..23 → hour-12.
  - Hours 1..12 are unchanged.
  - pm_led = (snapshot hour ≥ 12) when mode_24h=0; pm_led = 0 in 24h mode.
- Leading-zero blanking: in 12h mode, an H tens value of 0 is blanked (seg=7'h7F). In 24h mode the leading 0 is shown.
- Invalid input: an hour snapshot >23, or a minute/second snapshot >59, displays both digits of that field as dash (only g lit, seg=7'h3F). pm_led=0 for an invalid hour.
- Blink:
  - Blink counter counts 0..BLINK_DIV-1. On wrap the blink phase toggles.
  - When the phase is hidden and current_set_state selects a field, both digits of that field are blanked (seg=7'h7F). Their digit_en still scans, and dp is unaffected.
  - A change of current_set_state resets the blink counter to 0 and the phase to visible in the next cycle.
  - Set state 3 with NUM_DIGITS=4 blanks nothing.
- is_on=0: the next cycle forces digit_en=all 1, seg=7'h7F, dp=1, pm_led=0. Scan and blink counters hold at their reset values.
  - On return of is_on=1, scanning restarts at index 0 with a fresh snapshot and visible phase.
- Simultaneous events: reset dominates is_on. is_on=0 dominates blink restart. A set-state change on a blink-wrap cycle gives phase=visible.
- Reset mid-frame: applies in the same edge; no partial digit survives.

Test Plan:
- Reset/power: SCAN_DIV=4, BLINK_DIV=16, is_on=1, rst_n low 3 cycles then high → during reset digit_en=6'h3F, seg=7'h7F. After release, digit_en sequence is 3E,3D,3B,37,2F,1F, each held 4 cycles, starting 1 cycle after the index change.
- 12h conversion: hour=0, minute=5, mode_24h=0 → H tens blanked, H units "2"… correction: H digits show "12", with H tens "1" (seg=7'h79), H units "2" (seg=7'h24); pm_led=0. Then hour=13 → display "1", H tens blanked; pm_led=1 from the next frame only.
- 24h and invalid: mode_24h=1, hour=7 → H tens "0" (7'h40). hour=25 → both H digits 7'h3F, pm_led=0.
- Blink: current_set_state=2 → M digits blank for 16 cycles, visible for 16, repeating, while H and S digits are always lit. Change to 1 mid-hidden → H digits visible immediately, with the 16-cycle visible phase restarted.
- Snapshot coherence: change minute 59→0 while the index is 3 → the current frame keeps 59 and the next frame shows 00.
- Display off: is_on=0 mid-frame → next cycle digit_en=all 1, pm_led=0. Re-enable → first active digit_en=6'h3E.

Source files
------------

// File: rtl/clock_disp_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : clock_disp_scanner
//  Purpose  : Time-multiplexed seven-segment driver for the digital clock.
//             Shows HH:MM or HH:MM:SS in 12/24-hour form, blinks the field
//             being set, and freezes the time at the start of every frame.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_disp_scanner #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_on,
    input  logic                  mode_24h,
    input  logic [4:0]            hour,
    input  logic [5:0]            minute,
    input  logic [5:0]            second,
    input  logic [1:0]            current_set_state,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  pm_led
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [SCAN_W-1:0]  c_scan_max  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] c_blink_max = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   c_idx_max   = IDX_W'(NUM_DIGITS - 1);
    // Field numbering is 2=hour, 1=minute, 0=second; a 4-digit display starts at minutes.
    localparam logic [1:0]         c_field_ofs = 2'((6 - NUM_DIGITS) / 2);

    // Reject unsupported parameter values at elaboration time.
    generate
        if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_num_digits
            $error("clock_disp_scanner: NUM_DIGITS must be 4 or 6");
        end
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("clock_disp_scanner: SCAN_DIV must be at least 2");
        end
        if (BLINK_DIV < 2) begin : g_bad_blink_div
            $error("clock_disp_scanner: BLINK_DIV must be at least 2");
        end
    endgenerate

    logic [SCAN_W-1:0]     scan_cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [BLINK_W-1:0]    blink_cnt_q;
    logic                  blink_hidden_q;
    logic                  fresh_q;
    logic [1:0]            set_prev_q;
    logic [4:0]            snap_hour_q;
    logic [5:0]            snap_min_q;
    logic [5:0]            snap_sec_q;
    logic                  snap_24h_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] digit_en_q;
    logic                  pm_led_q;

    logic                  w_scan_wrap;
    logic                  w_frame_end;
    logic                  w_blink_wrap;
    logic                  w_set_changed;
    logic [4:0]            w_hour;
    logic [5:0]            w_min;
    logic [5:0]            w_sec;
    logic                  w_24h;
    logic                  w_hour_valid;
    logic [4:0]            w_disp_hour;
    logic                  w_pm;
    logic [1:0]            w_field;
    logic                  w_is_tens;
    logic [5:0]            w_field_val;
    logic                  w_field_valid;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_digit_en;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    assign w_scan_wrap   = (scan_cnt_q == c_scan_max);
    assign w_frame_end   = w_scan_wrap && (idx_q == c_idx_max);
    assign w_blink_wrap  = (blink_cnt_q == c_blink_max);
    assign w_set_changed = (current_set_state != set_prev_q);

    // The first active cycle renders the live inputs, which are also captured
    // on that edge, so frame 0 after reset or re-enable is never stale.
    assign w_hour = fresh_q ? hour     : snap_hour_q;
    assign w_min  = fresh_q ? minute   : snap_min_q;
    assign w_sec  = fresh_q ? second   : snap_sec_q;
    assign w_24h  = fresh_q ? mode_24h : snap_24h_q;

    // Digit content for the digit currently indexed.
    always_comb begin
        w_hour_valid = (w_hour <= 5'd23);
        if (w_24h)
            w_disp_hour = w_hour;
        else if (w_hour == 5'd0)
            w_disp_hour = 5'd12;
        else if (w_hour > 5'd12)
            w_disp_hour = w_hour - 5'd12;
        else
            w_disp_hour = w_hour;
        w_pm = !w_24h && w_hour_valid && (w_hour >= 5'd12);

        w_field   = 2'(idx_q >> 1) + c_field_ofs;
        w_is_tens = idx_q[0];
        case (w_field)
            2'd2: begin
                w_field_val   = {1'b0, w_disp_hour};
                w_field_valid = w_hour_valid;
            end
            2'd1: begin
                w_field_val   = w_min;
                w_field_valid = (w_min <= 6'd59);
            end
            default: begin
                w_field_val   = w_sec;
                w_field_valid = (w_sec <= 6'd59);
            end
        endcase
        w_digit = w_is_tens ? 4'(w_field_val / 6'd10) : 4'(w_field_val % 6'd10);

        // A set-state change restarts the blink as visible, including on the
        // very edge that sees the change.
        w_blank = blink_hidden_q && !w_set_changed &&
                  (current_set_state == (2'd3 - w_field));

        if (w_blank)
            w_seg = 7'h7F;
        else if (!w_field_valid)
            w_seg = 7'h3F;
        else if ((w_field == 2'd2) && w_is_tens && !w_24h && (w_digit == 4'd0))
            w_seg = 7'h7F;
        else
            w_seg = seg_decode(w_digit);

        w_dp = !(!w_is_tens && ((w_field == 2'd2) ||
                                ((w_field == 2'd1) && (NUM_DIGITS == 6))));
        w_digit_en = ~(NUM_DIGITS'(1) << idx_q);
    end

    // Scan and blink timebases; both park at their reset values while off.
    always_ff @(posedge clk) begin
        if (!rst_n || !is_on) begin
            scan_cnt_q     <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
            fresh_q        <= 1'b1;
        end else begin
            fresh_q <= 1'b0;
            if (w_scan_wrap) begin
                scan_cnt_q <= '0;
                idx_q      <= (idx_q == c_idx_max) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
            if (w_set_changed) begin
                blink_cnt_q    <= '0;
                blink_hidden_q <= 1'b0;
            end else if (w_blink_wrap) begin
                blink_cnt_q    <= '0;
                blink_hidden_q <= !blink_hidden_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // Time snapshot taken at frame start so one frame shows a single time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_hour_q <= '0;
            snap_min_q  <= '0;
            snap_sec_q  <= '0;
            snap_24h_q  <= 1'b0;
            set_prev_q  <= '0;
        end else begin
            set_prev_q <= current_set_state;
            if (is_on && (fresh_q || w_frame_end)) begin
                snap_hour_q <= hour;
                snap_min_q  <= minute;
                snap_sec_q  <= second;
                snap_24h_q  <= mode_24h;
            end
        end
    end

    // Registered pin drivers; everything dark in reset or when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n || !is_on) begin
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            digit_en_q <= '1;
            pm_led_q   <= 1'b0;
        end else begin
            seg_q      <= w_seg;
            dp_q       <= w_dp;
            digit_en_q <= w_digit_en;
            pm_led_q   <= w_pm;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign digit_en = digit_en_q;
    assign pm_led   = pm_led_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_disp_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_disp_scanner
//  Purpose  : Self-checking bench for clock_disp_scanner (6 digits, fast
//             scan/blink dividers) against a time-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_disp_scanner;

    localparam int N  = 6;
    localparam int SD = 4;
    localparam int BD = 16;

    logic         clk;
    logic         rst_n;
    logic         is_on;
    logic         mode_24h;
    logic [4:0]   hour;
    logic [5:0]   minute;
    logic [5:0]   second;
    logic [1:0]   set_st;
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] digit_en;
    logic         pm_led;

    clock_disp_scanner #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .is_on             (is_on),
        .mode_24h          (mode_24h),
        .hour              (hour),
        .minute            (minute),
        .second            (second),
        .current_set_state (set_st),
        .seg               (seg),
        .dp                (dp),
        .digit_en          (digit_en),
        .pm_led            (pm_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: active cycles since enable, cycles since blink
    // restart, and the time shown by the current frame.
    int  t = 0;
    int  b = 0;
    bit  fresh = 1;
    int  prev_set = 0;
    int  fh = 0, fm = 0, fs = 0;
    bit  f24 = 0;

    logic [6:0]   exp_seg;
    logic         exp_dp;
    logic [N-1:0] exp_en;
    logic         exp_pm;

    task automatic model_edge();
        int  idx, pos, field, val, dig, sset;
        bit  changed, hidden, tens, valid;
        sset = int'(set_st);
        if (!rst_n || !is_on) begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_en = '1; exp_pm = 1'b0;
            t = 0; b = 0; fresh = 1;
            prev_set = rst_n ? sset : 0;
            return;
        end
        changed = (sset != prev_set);
        if (fresh) begin
            fh = int'(hour); fm = int'(minute); fs = int'(second); f24 = mode_24h;
        end
        hidden = !changed && (((b / BD) % 2) == 1);
        idx    = (t / SD) % N;
        pos    = N - 1 - idx;           // 0 = leftmost digit
        field  = pos / 2;               // 0 hour, 1 minute, 2 second
        tens   = (pos % 2) == 0;
        if (field == 0) begin
            valid = fh <= 23;
            val   = f24 ? fh : ((fh % 12 == 0) ? 12 : fh % 12);
        end else if (field == 1) begin
            valid = fm <= 59; val = fm;
        end else begin
            valid = fs <= 59; val = fs;
        end
        dig = tens ? val / 10 : val % 10;
        if (hidden && sset == field + 1)         exp_seg = 7'h7F;
        else if (!valid)                         exp_seg = 7'h3F;
        else if (field == 0 && tens && !f24 && dig == 0) exp_seg = 7'h7F;
        else                                     exp_seg = seg_tab[dig];
        exp_dp = !(pos == 1 || pos == 3);
        exp_en = '1;
        exp_en[idx] = 1'b0;
        exp_pm = !f24 && fh <= 23 && fh >= 12;
        if ((t % (SD * N)) == SD * N - 1) begin
            fh = int'(hour); fm = int'(minute); fs = int'(second); f24 = mode_24h;
        end
        t = t + 1;
        b = changed ? 0 : b + 1;
        fresh = 0;
        prev_set = sset;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("seg",      {1'b0, seg},      {1'b0, exp_seg});
        chk("dp",       {7'b0, dp},       {7'b0, exp_dp});
        chk("digit_en", {2'b0, digit_en}, {2'b0, exp_en});
        chk("pm_led",   {7'b0, pm_led},   {7'b0, exp_pm});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; is_on = 1'b1; mode_24h = 1'b1;
        hour = 5'd10; minute = 6'd30; second = 6'd45; set_st = 2'd0;
        // Reset held for 3 edges, then two full frames of scanning.
        run(3);
        rst_n = 1'b1;
        run(2 * SD * N);
        // 12-hour display of midnight, then 1 PM mid-frame.
        mode_24h = 1'b0; hour = 5'd0; minute = 6'd5;
        run(2 * SD * N);
        run(7);
        hour = 5'd13;
        run(2 * SD * N);
        // 24-hour leading zero, then invalid hour and minute.
        mode_24h = 1'b1; hour = 5'd7;
        run(2 * SD * N);
        hour = 5'd25; minute = 6'd61; mode_24h = 1'b0;
        run(2 * SD * N);
        // Blink the minute field, then move to hour while hidden.
        hour = 5'd14; minute = 6'd27; second = 6'd8;
        set_st = 2'd2;
        run(24);
        set_st = 2'd1;
        run(40);
        set_st = 2'd3;
        run(40);
        set_st = 2'd0;
        // Minute rolls over while the minute-tens digit is being scanned.
        minute = 6'd59;
        run(2 * SD * N);
        while (digit_en !== 6'h37) tick();
        minute = 6'd0;
        run(2 * SD * N);
        // Display off mid-frame, then back on.
        run(5);
        is_on = 1'b0;
        run(6);
        is_on = 1'b1;
        run(SD * N + 3);
        // Reset mid-frame.
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(SD * N);
        // Randomised soak.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) hour     = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7)  == 0) minute   = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3)  == 0) second   = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 40) == 0) mode_24h = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 50) == 0) set_st   = 2'($urandom_range(0, 3));
            is_on = ($urandom_range(0, 60) != 0);
            rst_n = ($urandom_range(0, 150) != 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
